// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch stage and its prefetch FIFO.
//   BUBBLE        - all-ones opcode; the pipeline's default path turns it into a no-op with result 0
//   OPC_*         - opcode field values understood by the downstream pipeline
//   fetch_state_t - fetch FSM states
//   fetch_entry_t - one buffered fetch {pc, instr} for 32-bit addresses
package fetch_pkg;

  localparam logic [5:0]  OPC_NOP    = 6'b000000;
  localparam logic [5:0]  OPC_ADD    = 6'b000001;
  localparam logic [5:0]  OPC_SUB    = 6'b000010;
  localparam logic [5:0]  OPC_LOAD   = 6'b000011;
  localparam logic [5:0]  OPC_BUBBLE = 6'b111111;

  localparam logic [31:0] BUBBLE = {OPC_BUBBLE, 26'd0};

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset (async active-low)
//   push/wdata - write an entry (accepted when not full, or when full with a pop)
//   pop/rdata  - rdata shows the head; pop on empty is ignored
//   clear      - empty the FIFO (wins over push/pop)
//   count, full, empty - occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch stage in front of the 4-stage pipeline.
//   clk, reset (async active-low)
//   imem_req_valid/ready/addr - in-order word read requests to instruction memory
//   imem_rsp_valid/data       - in-order responses, no backpressure
//   redirect_valid/pc         - load a new PC and flush buffered and in-flight fetches
//   stall                     - hold the output register and FIFO
//   instr_out/instr_pc/instr_valid - registered instruction presented to the pipeline
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   pc;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W+31:0]  fifo_rdata;
  logic                req_enable;
  logic [SUM_W-1:0]    credit_sum;
  logic                req_fire;
  logic                rsp_keep;
  logic                bypass;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ADDR_W-1:0]   rsp_pc;
  logic [CNT_W-1:0]    drop_after_redirect;

  // Every slot that is dropping, in flight or buffered consumes one credit,
  // so the FIFO can never overflow even while the output is stalled.
  assign credit_sum = SUM_W'(drop_cnt) + SUM_W'(outstanding) + SUM_W'(fifo_count);

  assign imem_req_valid = req_enable && !redirect_valid &&
                          (credit_sum < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are in order, so once stale ones are dropped the oldest live
  // request sits 'outstanding' words behind the current PC.
  assign rsp_keep = imem_rsp_valid && (drop_cnt == {CNT_W{1'b0}}) && !redirect_valid;
  assign rsp_pc   = pc - (ADDR_W'(outstanding) << 2);

  // An empty FIFO and a moving pipeline let a response go straight to the output register.
  assign bypass    = rsp_keep && fifo_empty && !stall;
  assign fifo_push = rsp_keep && !bypass && (!fifo_full || fifo_pop);
  assign fifo_pop  = !redirect_valid && !stall && !fifo_empty;

  // Stale responses still owed after a redirect; one arriving in the redirect cycle is already gone.
  always_comb begin
    drop_after_redirect = drop_cnt + outstanding;
    if (imem_rsp_valid && (drop_after_redirect != {CNT_W{1'b0}})) begin
      drop_after_redirect = drop_after_redirect - CNT_W'(1);
    end else begin
      drop_after_redirect = drop_cnt + outstanding;
    end
  end

  // Fetch FSM: PC, request/drop accounting and state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= {CNT_W{1'b0}};
      drop_cnt    <= {CNT_W{1'b0}};
      req_enable  <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & ~ADDR_W'(3);
      outstanding <= {CNT_W{1'b0}};
      drop_cnt    <= drop_after_redirect;
      state       <= (drop_after_redirect != {CNT_W{1'b0}}) ? DRAIN : FETCH;
      req_enable  <= 1'b1;
    end else begin
      req_enable <= 1'b1;
      if (req_fire) begin
        pc <= pc + ADDR_W'(4);
      end
      case ({req_fire, rsp_keep})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (imem_rsp_valid && (drop_cnt != {CNT_W{1'b0}})) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      case (state)
        FETCH: state <= FETCH;
        DRAIN: begin
          if ((drop_cnt == {CNT_W{1'b0}}) ||
              (imem_rsp_valid && (drop_cnt == CNT_W'(1)))) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Output register: redirect forces a bubble even under stall; instr_pc keeps its last value on bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_out   <= BUBBLE;
      instr_pc    <= {ADDR_W{1'b0}};
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instr_out   <= BUBBLE;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr_out   <= fifo_rdata[31:0];
        instr_pc    <= fifo_rdata[ADDR_W+31:32];
        instr_valid <= 1'b1;
      end else if (bypass) begin
        instr_out   <= imem_rsp_data;
        instr_pc    <= rsp_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_out   <= BUBBLE;
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .wdata ({rsp_pc, imem_rsp_data}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
